mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning the address width.
REQ-003 The block SHALL have parameter LAT, default 1, legal range 1..15, meaning the memory access cycles per transaction.
REQ-004 The block SHALL have one clock and a synchronous active-high reset.
REQ-005 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 Port reset  input  1  SHALL be the synchronous active-high reset.
REQ-007 Port req0  input  1  SHALL be the fetch-side request (read-only requester).
REQ-008 Port addr0  input  ADDR_W  SHALL be the fetch-side address.
REQ-009 Port req1  input  1  SHALL be the data-side request.
REQ-010 Port addr1  input  ADDR_W  SHALL be the data-side address.
REQ-011 Port we1  input  1  SHALL be the data-side write enable.
REQ-012 Port wdata1  input  DATA_W  SHALL be the data-side write data.
REQ-013 Port ack0, ack1  output  1 each  SHALL be one-cycle completion pulses per requester.
REQ-014 Port rdata  output  DATA_W  SHALL be the read data, valid while the matching ack is high.
REQ-015 Port sel  output  1  SHALL be the shared-port mux select: 0 = requester 0, 1 = requester 1.
REQ-016 Port mem_en  output  1  SHALL be the memory access enable.
REQ-017 Port mem_we  output  1  SHALL be the memory write enable.
REQ-018 Port mem_addr  output  ADDR_W  SHALL be the memory address.
REQ-019 Port mem_wdata  output  DATA_W  SHALL be the memory write data.
REQ-020 Port mem_rdata  input  DATA_W  SHALL be the memory read data, valid in the last BUSY cycle.
REQ-021 Port busy  output  1  SHALL be high in every state other than IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY and ACK.
REQ-023 In IDLE with any req high, at the clock edge the FSM SHALL latch owner (registered into sel), load cnt=LAT-1 and enter BUSY; with no req high it SHALL stay in IDLE.
REQ-024 Arbitration SHALL be round-robin: with only one req high, that requester wins; with both high, the requester not equal to last_grant wins; last_grant SHALL update to the winner on entry to BUSY.
REQ-025 In BUSY, mem_en SHALL be 1, mem_addr/mem_wdata SHALL be muxed from the owner by sel, and mem_we SHALL equal owner==1 && we1 (we1 sampled at grant and held).
REQ-026 In BUSY, cnt SHALL decrement each cycle; at cnt==0 the block SHALL capture mem_rdata into rdata and enter ACK.
REQ-027 In ACK, ack[owner] SHALL be 1 for exactly one cycle and mem_en SHALL be 0, then the FSM SHALL return to IDLE.
REQ-028 Latency SHALL be LAT+1 cycles from the edge that samples req to the cycle ack is high; there SHALL be one IDLE cycle between consecutive grants.
REQ-029 Requesters SHALL hold req, addr, we1 and wdata1 stable until ack; a req that falls during BUSY SHALL NOT abort the transaction (ack still pulses).
REQ-030 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-031 sel SHALL hold its last value in IDLE and ACK.
REQ-032 For a write, rdata SHALL still be updated from mem_rdata per REQ-026, with no other meaning attached.
REQ-033 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-034 With reset high at an edge, the block SHALL enter IDLE with sel=0, last_grant=1, cnt=0, rdata=0, ack0=ack1=0, mem_en=mem_we=0 and busy=0, regardless of the request inputs.
REQ-035 Reset during BUSY or ACK SHALL abort the transaction: no ack SHALL follow, and mem_en SHALL be 0 in the cycle after the reset edge.
REQ-036 After reset deasserts, the first contended grant SHALL go to requester 0.

Verification
REQ-037 Single read, LAT=1: req0=1, addr0=0x0010, mem returns 0x1234 -> sel=0, mem_en high 1 cycle, ack0 high 2 cycles after the sample edge, rdata=0x1234.
REQ-038 Single write, LAT=2: req1=1, we1=1, addr1=0x4000, wdata1=0xBEEF -> sel=1, mem_we=mem_en=1 for 2 cycles with mem_addr=0x4000 and mem_wdata=0xBEEF, then ack1 for 1 cycle.
REQ-039 Contention: req0=req1=1 held after reset -> grants alternate 0,1,0,1; each ack is 1 cycle; ack0 and ack1 never coincide.
REQ-040 Request drop: req1 deasserted in the first BUSY cycle -> the transaction completes and ack1 still pulses.
REQ-041 Reset mid-access, LAT=3: reset in the second BUSY cycle -> next cycle IDLE, all outputs at reset values, no ack.
REQ-042 Back-to-back: req0 kept high after ack0 -> one IDLE cycle, then a new grant to requester 0 with a second ack0 LAT+1 cycles later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter sharing one single-port memory between a
//            read-only fetch requester (0) and a read/write data requester (1).
//            Each granted transaction holds the memory port for LAT cycles,
//            then pulses the owner's ack for one cycle with the read data.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req0/addr0           - fetch-side request and address
//            req1/addr1/we1/wdata1- data-side request, address, write, data
//            ack0/ack1            - one-cycle completion pulses
//            rdata                - read data, valid while an ack is high
//            sel                  - shared-port mux select (owner)
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//            busy                 - high whenever a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       we_hold;
  logic       winner;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    // Under contention the requester that did not win last time goes next;
    // otherwise the lone requester wins (req1 alone -> 1, req0 alone -> 0).
    winner     = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        mem_we = sel && we_hold;
        if (cnt == 4'd0) begin
          state_next = ACK;
        end
      end
      ACK: begin
        busy       = 1'b1;
        ack0       = ~sel;
        ack1       = sel;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Requesters hold address/data stable until ack, so the port can be a
  // plain mux on the registered owner. Requester 0 never writes.
  assign mem_addr  = sel ? addr1 : addr0;
  assign mem_wdata = sel ? wdata1 : '0;

  // Grant bookkeeping, access counter and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      rdata      <= '0;
      we_hold    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel        <= winner;
            last_grant <= winner;
            cnt        <= CNT_LOAD;
            we_hold    <= winner && we1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Three instances run
//            side by side with LAT = 1, 2, 3; a transaction-level model
//            (grant record + age in cycles since grant) predicts every output
//            each cycle. Directed scenarios pin the model with literal values,
//            then randomized protocol-respecting traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         rst, req0, req1, we1;
  logic [N-1:0][AW-1:0] addr0, addr1, mem_addr;
  logic [N-1:0][DW-1:0] wdata1, rdata, mem_wdata, mem_rdata;
  logic [N-1:0]         ack0, ack1, sel, mem_en, mem_we, busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Memory contents as a pure function of address
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == AW'(16'h0010)) return 16'h1234;
    return DW'((32'(a) * 32'h9E37) ^ 32'h5A5A);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LAT(g + 1)) dut (
      .clk(clk), .reset(rst[g]),
      .req0(req0[g]), .addr0(addr0[g]),
      .req1(req1[g]), .addr1(addr1[g]), .we1(we1[g]), .wdata1(wdata1[g]),
      .ack0(ack0[g]), .ack1(ack1[g]), .rdata(rdata[g]), .sel(sel[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
    assign mem_rdata[g] = memf(mem_addr[g]);
  end

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit              m_active[N];
  int              m_age[N];     // 1..LAT = access cycles, LAT+1 = ack cycle
  bit              m_sel[N];
  bit              m_lastg[N];
  bit              m_we[N];
  logic [AW-1:0]   m_addr[N];
  logic [DW-1:0]   m_wdata[N];
  logic [DW-1:0]   m_rdata[N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        m_active[i] = 1'b0; m_age[i] = 0; m_sel[i] = 1'b0; m_lastg[i] = 1'b1;
        m_rdata[i] = '0; m_we[i] = 1'b0;
      end else if (m_active[i]) begin
        if (m_age[i] == i + 1) m_rdata[i] = memf(m_addr[i]);
        m_age[i] = m_age[i] + 1;
        if (m_age[i] == i + 3) m_active[i] = 1'b0;
      end else if (req0[i] || req1[i]) begin
        m_sel[i]    = (req0[i] && req1[i]) ? !m_lastg[i] : req1[i];
        m_lastg[i]  = m_sel[i];
        m_addr[i]   = m_sel[i] ? addr1[i] : addr0[i];
        m_wdata[i]  = wdata1[i];
        m_we[i]     = m_sel[i] && we1[i];
        m_active[i] = 1'b1;
        m_age[i]    = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        bit e_en, e_ack;
        e_en  = m_active[i] && (m_age[i] <= i + 1);
        e_ack = m_active[i] && (m_age[i] == i + 2);
        chk("busy",   i, 32'(busy[i]),   32'(m_active[i]));
        chk("mem_en", i, 32'(mem_en[i]), 32'(e_en));
        chk("mem_we", i, 32'(mem_we[i]), 32'(e_en && m_sel[i] && m_we[i]));
        chk("ack0",   i, 32'(ack0[i]),   32'(e_ack && !m_sel[i]));
        chk("ack1",   i, 32'(ack1[i]),   32'(e_ack && m_sel[i]));
        chk("ack_excl", i, 32'(ack0[i] && ack1[i]), 32'(0));
        chk("sel",    i, 32'(sel[i]),    32'(m_sel[i]));
        chk("rdata",  i, 32'(rdata[i]),  32'(m_rdata[i]));
        if (e_en) chk("mem_addr", i, 32'(mem_addr[i]), 32'(m_addr[i]));
        if (e_en && m_sel[i] && m_we[i])
          chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(m_wdata[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  bit p0[N], p1[N];
  int order[$];
  int seen;

  initial begin
    rst = '1; req0 = '0; req1 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata1 = '0;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    tick();
    rst = '0;
    tick();
    for (int i = 0; i < N; i++) begin
      chk("rst_sel", i, 32'(sel[i]), 32'(0));
      chk("rst_busy", i, 32'(busy[i]), 32'(0));
      chk("rst_rdata", i, 32'(rdata[i]), 32'(0));
      chk("rst_mem_en", i, 32'(mem_en[i]), 32'(0));
    end

    // Single read, LAT=1
    req0[0] = 1'b1; addr0[0] = AW'(16'h0010);
    tick();
    chk("rd_mem_en", 0, 32'(mem_en[0]), 32'(1));
    chk("rd_sel", 0, 32'(sel[0]), 32'(0));
    chk("rd_mem_addr", 0, 32'(mem_addr[0]), 32'h0010);
    tick();
    chk("rd_ack0", 0, 32'(ack0[0]), 32'(1));
    chk("rd_rdata", 0, 32'(rdata[0]), 32'h1234);
    chk("rd_mem_en_off", 0, 32'(mem_en[0]), 32'(0));
    req0[0] = 1'b0;
    tick();
    chk("rd_idle", 0, 32'(busy[0]), 32'(0));

    // Single write, LAT=2
    req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = AW'(16'h4000); wdata1[1] = 16'hBEEF;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("wr_mem_we", 1, 32'(mem_we[1]), 32'(1));
      chk("wr_mem_en", 1, 32'(mem_en[1]), 32'(1));
      chk("wr_mem_addr", 1, 32'(mem_addr[1]), 32'h4000);
      chk("wr_mem_wdata", 1, 32'(mem_wdata[1]), 32'hBEEF);
      chk("wr_sel", 1, 32'(sel[1]), 32'(1));
      tick();
    end
    chk("wr_ack1", 1, 32'(ack1[1]), 32'(1));
    chk("wr_mem_en_off", 1, 32'(mem_en[1]), 32'(0));
    req1[1] = 1'b0; we1[1] = 1'b0;
    tick();
    chk("wr_ack1_once", 1, 32'(ack1[1]), 32'(0));

    // Request dropped in first access cycle, LAT=2
    req1[1] = 1'b1; addr1[1] = AW'(16'h0300);
    tick();
    req1[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      tick();
      if (ack1[1]) begin
        seen = 1;
        chk("drop_rdata", 1, 32'(rdata[1]), 32'(memf(AW'(16'h0300))));
      end
    end
    chk("drop_ack1_seen", 1, 32'(seen), 32'(1));

    // Reset in second access cycle, LAT=3
    req0[2] = 1'b1; addr0[2] = AW'(16'h0005);
    tick();
    tick();
    chk("rst_mid_busy_before", 2, 32'(mem_en[2]), 32'(1));
    rst[2] = 1'b1;
    tick();
    chk("rst_mid_busy", 2, 32'(busy[2]), 32'(0));
    chk("rst_mid_mem_en", 2, 32'(mem_en[2]), 32'(0));
    chk("rst_mid_sel", 2, 32'(sel[2]), 32'(0));
    chk("rst_mid_rdata", 2, 32'(rdata[2]), 32'(0));
    rst[2] = 1'b0; req0[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_mid_no_ack", 2, 32'(ack0[2]), 32'(0));
    end

    // Back-to-back on requester 0, LAT=1
    req0[0] = 1'b1; addr0[0] = AW'(16'h0020);
    tick(); tick();
    chk("b2b_ack_a", 0, 32'(ack0[0]), 32'(1));
    tick();
    chk("b2b_idle_gap", 0, 32'(busy[0]), 32'(0));
    tick();
    chk("b2b_regrant", 0, 32'(mem_en[0]), 32'(1));
    tick();
    chk("b2b_ack_b", 0, 32'(ack0[0]), 32'(1));
    req0[0] = 1'b0;
    tick();

    // Contention after reset, LAT=1: grants alternate starting with 0
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    req0[0] = 1'b1; req1[0] = 1'b1; we1[0] = 1'b0;
    addr0[0] = AW'(16'h0100); addr1[0] = AW'(16'h0200);
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      tick();
      if (ack0[0]) order.push_back(0);
      if (ack1[0]) order.push_back(1);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("cont_count", 0, 32'(order.size()), 32'(4));
    for (int k = 0; k < order.size(); k++)
      chk("cont_order", 0, 32'(order[k]), 32'(k % 2));
    tick(); tick(); tick();

    // Randomized protocol-respecting traffic on all instances
    for (int i = 0; i < N; i++) begin p0[i] = 1'b0; p1[i] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        bit a0, a1, g1;
        a0 = m_active[i] && m_age[i] == i + 2 && !m_sel[i];
        a1 = m_active[i] && m_age[i] == i + 2 && m_sel[i];
        g1 = m_active[i] && m_age[i] == 1;
        if (rst[i]) begin
          rst[i] = 1'b0; req0[i] = 1'b0; req1[i] = 1'b0; p0[i] = 1'b0; p1[i] = 1'b0;
        end else if ($urandom_range(149) == 0) begin
          rst[i] = 1'b1;
        end else begin
          if (p0[i] && a0) p0[i] = 1'b0;
          if (!p0[i]) begin
            if ($urandom_range(2) == 0) begin
              req0[i] = 1'b1; addr0[i] = AW'($urandom); p0[i] = 1'b1;
            end else begin
              req0[i] = 1'b0;
            end
          end else if (g1 && !m_sel[i] && $urandom_range(7) == 0) begin
            req0[i] = 1'b0;
          end
          if (p1[i] && a1) p1[i] = 1'b0;
          if (!p1[i]) begin
            if ($urandom_range(2) == 0) begin
              req1[i] = 1'b1; addr1[i] = AW'($urandom); we1[i] = 1'($urandom);
              wdata1[i] = DW'($urandom); p1[i] = 1'b1;
            end else begin
              req1[i] = 1'b0;
            end
          end else if (g1 && m_sel[i] && $urandom_range(7) == 0) begin
            req1[i] = 1'b0;
          end
        end
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
